// File: rtl/bus_pkg.sv
// Memory-bus definitions shared by the caches and the bus arbiter.
// Latency: none (types/constants only); backpressure: not applicable.
package bus_pkg;

    localparam int BUS_DATA_WIDTH = 64;
    localparam int BUS_TAG_WIDTH  = 13;
    localparam int LINE_BEATS     = 8;

    localparam logic [BUS_TAG_WIDTH-1:0] MEM_READ  = BUS_TAG_WIDTH'(1);
    localparam logic [BUS_TAG_WIDTH-1:0] MEM_WRITE = BUS_TAG_WIDTH'(2);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ADDR  = 2'd1,
        ARB_WDATA = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; priority flips to the non-owner on release.
// Latency: combinational grant; backpressure: none, caller decides when to use grant.
module rr_arb2
    import bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       release_grant,
    input  logic [1:0] owner,
    output logic [1:0] grant
);

    // 0 favours req[0] (icache), 1 favours req[1] (dcache)
    logic prio_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else if (release_grant) begin
            prio_q <= owner[0];
        end
    end

    always_comb begin
        grant = 2'b00;
        if (req == 2'b01) begin
            grant = 2'b01;
        end else if (req == 2'b10) begin
            grant = 2'b10;
        end else if (req == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between icache and dcache, holding the grant for a whole line.
// Latency: 1 cycle to grant, then zero-latency pass-through; backpressure: bus_reqack relayed to the owner.
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = bus_pkg::BUS_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = bus_pkg::BUS_TAG_WIDTH,
    parameter int LINE_BEATS     = bus_pkg::LINE_BEATS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    output logic                      i_reqack,
    output logic                      i_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] i_resp,
    output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
    input  logic                      d_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    output logic                      d_reqack,
    output logic                      d_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] d_resp,
    output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic [1:0]                owner
);

    localparam int BEAT_W = $clog2(LINE_BEATS);

    bus_pkg::arb_state_t state_q, state_d;
    logic [1:0]        owner_q, owner_d, grant;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              rel, own_i, owner_reqcyc, last_beat;

    // icache requests are always reads, so its tag carries nothing we need
    logic unused_i_reqtag;
    assign unused_i_reqtag = ^i_reqtag;

    assign own_i        = owner_q[0];
    assign owner_reqcyc = own_i ? i_reqcyc : d_reqcyc;
    assign last_beat    = (beat_q == BEAT_W'(LINE_BEATS - 1));
    assign owner        = owner_q;

    rr_arb2 u_rr_arb2 (
        .clk           (clk),
        .reset         (reset),
        .req           ({d_reqcyc, i_reqcyc}),
        .release_grant (rel),
        .owner         (owner_q),
        .grant         (grant)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= bus_pkg::ARB_IDLE;
            owner_q <= 2'b00;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        beat_d      = beat_q;
        rel         = 1'b0;
        i_reqack    = 1'b0;
        i_respcyc   = 1'b0;
        i_resp      = '0;
        i_resptag   = '0;
        d_reqack    = 1'b0;
        d_respcyc   = 1'b0;
        d_resp      = '0;
        d_resptag   = '0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;

        case (state_q)
            bus_pkg::ARB_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d = grant;
                    beat_d  = '0;
                    state_d = bus_pkg::ARB_ADDR;
                end
            end
            bus_pkg::ARB_ADDR: begin
                bus_reqcyc = owner_reqcyc;
                bus_req    = own_i ? i_req : d_req;
                bus_reqtag = own_i ? bus_pkg::MEM_READ : d_reqtag;
                i_reqack   = own_i && i_reqcyc && bus_reqack;
                d_reqack   = !own_i && d_reqcyc && bus_reqack;
                // a withdrawn request is not a completed line, so priority stays put
                if (!owner_reqcyc) begin
                    owner_d = 2'b00;
                    state_d = bus_pkg::ARB_IDLE;
                end else if (bus_reqack) begin
                    state_d = (!own_i && d_reqtag == bus_pkg::MEM_WRITE) ?
                              bus_pkg::ARB_WDATA : bus_pkg::ARB_RESP;
                end
            end
            bus_pkg::ARB_WDATA: begin
                bus_reqcyc = d_reqcyc;
                bus_req    = d_req;
                bus_reqtag = bus_pkg::MEM_WRITE;
                d_reqack   = d_reqcyc && bus_reqack;
                if (d_reqcyc && bus_reqack) begin
                    if (last_beat) begin
                        rel     = 1'b1;
                        owner_d = 2'b00;
                        beat_d  = '0;
                        state_d = bus_pkg::ARB_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            bus_pkg::ARB_RESP: begin
                bus_respack = bus_respcyc;
                if (own_i) begin
                    i_respcyc = bus_respcyc;
                    i_resp    = bus_resp;
                    i_resptag = bus_resptag;
                end else begin
                    d_respcyc = bus_respcyc;
                    d_resp    = bus_resp;
                    d_resptag = bus_resptag;
                end
                if (bus_respcyc) begin
                    if (last_beat) begin
                        rel     = 1'b1;
                        owner_d = 2'b00;
                        beat_d  = '0;
                        state_d = bus_pkg::ARB_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                owner_d = 2'b00;
                beat_d  = '0;
                state_d = bus_pkg::ARB_IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single memory bus between the instruction cache and the data cache. Each cache issues whole-line transactions: a read is one address beat plus 8 response beats; a data write-back is one address beat plus 8 data beats. The arbiter grants one owner at a time with round-robin priority and holds the grant until the line completes. It sits between the two cache instances and the top-level bus pins.

## Interface
- BUS_DATA_WIDTH, 64, width of bus data, address and response beats
- BUS_TAG_WIDTH, 13, width of bus tags
- LINE_BEATS, 8, beats per 64-byte line
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low; clock clk
- i_reqcyc / i_req / i_reqtag  in  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  icache request (address, tag)
- i_reqack  out  1  icache request accepted
- i_respcyc / i_resp / i_resptag  out  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  response beat to icache
- d_reqcyc / d_req / d_reqtag  in  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  dcache address beat, then write data beats
- d_reqack  out  1  dcache beat accepted
- d_respcyc / d_resp / d_resptag  out  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  response beat to dcache
- bus_reqcyc / bus_req / bus_reqtag  out  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  bus request
- bus_reqack  in  1  bus accepted beat
- bus_respcyc / bus_resp / bus_resptag  in  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  bus response beat
- bus_respack  out  1  response beat consumed
- owner  out  2  00 none, 01 icache, 10 dcache

## Operation
- **States:** ARB_IDLE, ARB_ADDR, ARB_WDATA, ARB_RESP.
- **ARB_IDLE:** sample i_reqcyc/d_reqcyc. If only one is high, grant that cache. If both are high, grant the cache named by the priority bit. Register the owner and go to ARB_ADDR.
- **ARB_ADDR:** bus_reqcyc, bus_req and bus_reqtag mirror the owner's inputs. The owner's ack is bus_reqack passed through in the same cycle. On bus_reqack:
  - tag MEM_WRITE from dcache → ARB_WDATA;
  - otherwise → ARB_RESP.
- **icache tag:** always driven as MEM_READ, whatever i_reqtag holds.
- **ARB_WDATA:** mirror d_reqcyc/d_req with tag MEM_WRITE. Each cycle with bus_reqcyc && bus_reqack counts one beat. On the beat where beat_cnt == LINE_BEATS-1, release the grant and go to ARB_IDLE.
- **ARB_RESP:**
  - bus_respack = bus_respcyc, combinational.
  - The owner's respcyc/resp/resptag mirror the bus response.
  - Each bus_respcyc cycle counts one beat. On the 8th beat, release and go to ARB_IDLE.
- **Outside ARB_RESP:** bus_respack = 0. A stray bus_respcyc is neither acked nor forwarded.
- **Non-owner outputs:** reqack, respcyc, resp and resptag are all 0.
- **Priority on release:** the priority bit points to the requester that was not the owner.
- **Requester contract:** a requester holds reqcyc and its data stable until acked. Dropping reqcyc in ARB_ADDR before the ack returns the arbiter to ARB_IDLE, with the priority bit unchanged.
- **beat_cnt:** $clog2(LINE_BEATS) bits. It clears on every grant and never wraps mid-line.
- **Reset (reset == 0 at a clk edge), including mid-transaction:**
  - state ARB_IDLE, owner 00, beat_cnt 0, priority = icache;
  - every output 0;
  - the bus transaction in flight is abandoned.

## Timing
- **Grant latency:** a request seen in ARB_IDLE at edge N appears on bus_reqcyc in cycle N+1.
- **Back-to-back:** the cycle after the last beat is ARB_IDLE, and the next grant is visible one cycle after that. The minimum gap between transactions is therefore 1 idle cycle.
- **Pass-through:** request and response paths are purely combinational through the registered owner, with no added beat latency.
- **Throughput:** one beat per cycle when the bus acks every cycle.
- **Same-edge events:** a final beat and a new request on the same edge are both honored. The request is granted from ARB_IDLE with the updated priority.

## Structure
- **Shared package (bus_pkg), also used by the cache:** MEM_READ, MEM_WRITE, BUS_DATA_WIDTH, BUS_TAG_WIDTH, LINE_BEATS, and the arb_state_t enum.
- **Sub-module rr_arb2:** 2-input round-robin pick with a priority flip on release. Inputs req[1:0] and release; output grant[1:0].
- **Top module:** holds the FSM, beat counter and muxes.

## Test plan
- **Single icache read:** i_reqcyc with address 0x1000, bus acks in cycle 2, then 8 resp beats 0xA0..0xA7 → i_respcyc pulses 8 times with data 0xA0..0xA7, bus_respack matches every beat, owner returns to 00, d_resp stays 0.
- **Simultaneous requests after reset:** icache granted first. At the icache release, dcache is granted one cycle later. A third simultaneous pair is then granted to icache.
- **dcache write-back:** MEM_WRITE address 0x2040, then 8 data beats 0xD0..0xD7, with bus_reqack held low for 2 cycles on beat 3 → exactly 8 beats forwarded in order, no ARB_RESP, return to ARB_IDLE.
- **Stray response:** bus_respcyc = 1 while in ARB_IDLE or ARB_ADDR → bus_respack = 0, no i_respcyc/d_respcyc.
- **Reset mid-line:** reset low after response beat 4 of a dcache read → next cycle all outputs 0, owner 00. After reset releases, a new icache request is granted in 1 cycle and beat_cnt counts from 0.
- **icache tag forcing:** i_reqtag = MEM_WRITE → bus_reqtag = MEM_READ, and the arbiter enters ARB_RESP.
